// File: rtl/pipeline_hazard_regs_if.sv
// Bus between the decode control path and the ID->EX->MEM->WB control pipeline:
// decoded ID inputs and redirect in, stage contents, hazard controls and counters out.
interface pipeline_hazard_regs_if #(
  parameter int CTL_W      = 11,
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 32
);
  logic                  id_valid;
  logic [CTL_W-1:0]      id_ctl;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  ex_redirect;

  logic                  stall;
  logic                  flush_id;
  logic                  ex_valid;
  logic                  mem_valid;
  logic                  wb_valid;
  logic [CTL_W-1:0]      ex_ctl;
  logic [CTL_W-1:0]      mem_ctl;
  logic [CTL_W-1:0]      wb_ctl;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [1:0]            fwd_a_select;
  logic [1:0]            fwd_b_select;
  logic [COUNT_W-1:0]    load_use_count;
  logic [COUNT_W-1:0]    redirect_count;

  modport master (
    output id_valid, id_ctl, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, ex_redirect,
    input  stall, flush_id, ex_valid, mem_valid, wb_valid, ex_ctl, mem_ctl, wb_ctl,
    input  ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, fwd_a_select, fwd_b_select,
    input  load_use_count, redirect_count
  );

  modport slave (
    input  id_valid, id_ctl, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, ex_redirect,
    output stall, flush_id, ex_valid, mem_valid, wb_valid, ex_ctl, mem_ctl, wb_ctl,
    output ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, fwd_a_select, fwd_b_select,
    output load_use_count, redirect_count
  );
endinterface

// File: rtl/pipeline_hazard_regs.sv
// ID->EX->MEM->WB control pipeline registers with load-use stall, redirect squash,
// EX operand forwarding selects and saturating hazard event counters.
module pipeline_hazard_regs #(
  parameter int CTL_W      = 11,
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  pipeline_hazard_regs_if.slave bus
);
  localparam int RWE_BIT = CTL_W - 1;
  localparam int DMR_BIT = CTL_W - 2;
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = {REG_ADDR_W{1'b0}};
  localparam logic [CTL_W-1:0]      ZERO_CTL  = {CTL_W{1'b0}};
  localparam logic [COUNT_W-1:0]    ZERO_CNT  = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0]    CNT_MAX   = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0]    CNT_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};

  // Loads in MEM have no result yet, so only WB may forward a load; x0 never forwards.
  function automatic logic [1:0] fwd_select(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  mem_v,
    input logic [CTL_W-1:0]      mem_c,
    input logic [REG_ADDR_W-1:0] mem_a,
    input logic                  wb_v,
    input logic [CTL_W-1:0]      wb_c,
    input logic [REG_ADDR_W-1:0] wb_a
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (mem_v && mem_c[RWE_BIT] && !mem_c[DMR_BIT] && (mem_a != ZERO_ADDR) && (mem_a == src)) begin
      sel = 2'd1;
    end else if (wb_v && wb_c[RWE_BIT] && (wb_a != ZERO_ADDR) && (wb_a == src)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  logic                  r_ex_valid;
  logic [CTL_W-1:0]      r_ex_ctl;
  logic [REG_ADDR_W-1:0] r_ex_rs1;
  logic [REG_ADDR_W-1:0] r_ex_rs2;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_mem_valid;
  logic [CTL_W-1:0]      r_mem_ctl;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_wb_valid;
  logic [CTL_W-1:0]      r_wb_ctl;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [COUNT_W-1:0]    r_load_use_count;
  logic [COUNT_W-1:0]    r_redirect_count;

  logic                  w_rs1_hit;
  logic                  w_rs2_hit;
  logic                  w_load_use;
  logic                  w_stall;
  logic                  w_ex_valid_nxt;
  logic [CTL_W-1:0]      w_ex_ctl_nxt;
  logic [REG_ADDR_W-1:0] w_ex_rs1_nxt;
  logic [REG_ADDR_W-1:0] w_ex_rs2_nxt;
  logic [REG_ADDR_W-1:0] w_ex_rd_nxt;
  logic [1:0]            w_fwd_a;
  logic [1:0]            w_fwd_b;

  // Load-use detection and EX next-state; a redirect overrides the stall and squashes ID.
  always_comb begin
    w_rs1_hit      = 1'b0;
    w_rs2_hit      = 1'b0;
    w_load_use     = 1'b0;
    w_stall        = 1'b0;
    w_ex_valid_nxt = 1'b0;
    w_ex_ctl_nxt   = ZERO_CTL;
    w_ex_rs1_nxt   = ZERO_ADDR;
    w_ex_rs2_nxt   = ZERO_ADDR;
    w_ex_rd_nxt    = ZERO_ADDR;
    w_rs1_hit  = bus.id_uses_rs1 && (bus.id_rs1 == r_ex_rd);
    w_rs2_hit  = bus.id_uses_rs2 && (bus.id_rs2 == r_ex_rd);
    w_load_use = bus.id_valid && r_ex_valid && r_ex_ctl[DMR_BIT] &&
                 (r_ex_rd != ZERO_ADDR) && (w_rs1_hit || w_rs2_hit);
    w_stall    = w_load_use && !bus.ex_redirect;
    if (bus.ex_redirect || w_stall) begin
      w_ex_valid_nxt = 1'b0;
      w_ex_ctl_nxt   = ZERO_CTL;
    end else begin
      w_ex_valid_nxt = bus.id_valid;
      w_ex_ctl_nxt   = bus.id_valid ? bus.id_ctl : ZERO_CTL;
      w_ex_rs1_nxt   = bus.id_rs1;
      w_ex_rs2_nxt   = bus.id_rs2;
      w_ex_rd_nxt    = bus.id_rd;
    end
  end

  // EX operand forwarding selects.
  always_comb begin
    w_fwd_a = fwd_select(r_ex_rs1, r_mem_valid, r_mem_ctl, r_mem_rd, r_wb_valid, r_wb_ctl, r_wb_rd);
    w_fwd_b = fwd_select(r_ex_rs2, r_mem_valid, r_mem_ctl, r_mem_rd, r_wb_valid, r_wb_ctl, r_wb_rd);
  end

  // Stage registers; MEM and WB advance every cycle regardless of stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_ctl    <= ZERO_CTL;
      r_ex_rs1    <= ZERO_ADDR;
      r_ex_rs2    <= ZERO_ADDR;
      r_ex_rd     <= ZERO_ADDR;
      r_mem_valid <= 1'b0;
      r_mem_ctl   <= ZERO_CTL;
      r_mem_rd    <= ZERO_ADDR;
      r_wb_valid  <= 1'b0;
      r_wb_ctl    <= ZERO_CTL;
      r_wb_rd     <= ZERO_ADDR;
    end else begin
      r_ex_valid  <= w_ex_valid_nxt;
      r_ex_ctl    <= w_ex_ctl_nxt;
      r_ex_rs1    <= w_ex_rs1_nxt;
      r_ex_rs2    <= w_ex_rs2_nxt;
      r_ex_rd     <= w_ex_rd_nxt;
      r_mem_valid <= r_ex_valid;
      r_mem_ctl   <= r_ex_ctl;
      r_mem_rd    <= r_ex_rd;
      r_wb_valid  <= r_mem_valid;
      r_wb_ctl    <= r_mem_ctl;
      r_wb_rd     <= r_mem_rd;
    end
  end

  // Saturating event counters: they hold at all-ones instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_load_use_count <= ZERO_CNT;
      r_redirect_count <= ZERO_CNT;
    end else begin
      if (w_stall && (r_load_use_count != CNT_MAX)) begin
        r_load_use_count <= r_load_use_count + CNT_ONE;
      end else begin
        r_load_use_count <= r_load_use_count;
      end
      if (bus.ex_redirect && (r_redirect_count != CNT_MAX)) begin
        r_redirect_count <= r_redirect_count + CNT_ONE;
      end else begin
        r_redirect_count <= r_redirect_count;
      end
    end
  end

  assign bus.stall          = w_stall;
  assign bus.flush_id       = bus.ex_redirect;
  assign bus.ex_valid       = r_ex_valid;
  assign bus.mem_valid      = r_mem_valid;
  assign bus.wb_valid       = r_wb_valid;
  assign bus.ex_ctl         = r_ex_ctl;
  assign bus.mem_ctl        = r_mem_ctl;
  assign bus.wb_ctl         = r_wb_ctl;
  assign bus.ex_rs1         = r_ex_rs1;
  assign bus.ex_rs2         = r_ex_rs2;
  assign bus.ex_rd          = r_ex_rd;
  assign bus.mem_rd         = r_mem_rd;
  assign bus.wb_rd          = r_wb_rd;
  assign bus.fwd_a_select   = w_fwd_a;
  assign bus.fwd_b_select   = w_fwd_b;
  assign bus.load_use_count = r_load_use_count;
  assign bus.redirect_count = r_redirect_count;
endmodule

// File: tb/tb_pipeline_hazard_regs.sv
// Bench for pipeline_hazard_regs: directed hazard scenarios with literal expectations,
// then random traffic, all compared each cycle against a slot-array reference model.
module tb_pipeline_hazard_regs;
  localparam int CTL_W      = 11;
  localparam int REG_ADDR_W = 5;
  localparam int COUNT_W    = 6;
  localparam int CNT_MAX    = (1 << COUNT_W) - 1;

  localparam logic [10:0] CTL_LW  = 11'b1_1_0_001_00000;
  localparam logic [10:0] CTL_ADD = 11'b1_0_0_000_00001;
  localparam logic [10:0] CTL_SUB = 11'b1_0_0_000_00010;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pipeline_hazard_regs_if #(.CTL_W(CTL_W), .REG_ADDR_W(REG_ADDR_W), .COUNT_W(COUNT_W)) bus();

  pipeline_hazard_regs #(.CTL_W(CTL_W), .REG_ADDR_W(REG_ADDR_W), .COUNT_W(COUNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit        v;
    bit [10:0] ctl;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit [4:0]  rd;
  } slot_t;

  // slot[0]=EX, slot[1]=MEM, slot[2]=WB
  slot_t slot [3];
  int    m_lu_cnt;
  int    m_rd_cnt;
  int    vectors;
  int    miscompares;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) slot[i] = '{1'b0, 11'd0, 5'd0, 5'd0, 5'd0};
    m_lu_cnt = 0;
    m_rd_cnt = 0;
  endtask

  function automatic bit model_load_use();
    bit dep;
    dep = (bus.id_uses_rs1 && bus.id_rs1 == slot[0].rd) || (bus.id_uses_rs2 && bus.id_rs2 == slot[0].rd);
    return bus.id_valid && slot[0].v && slot[0].ctl[9] && slot[0].rd != 5'd0 && dep;
  endfunction

  function automatic int model_fwd(input bit [4:0] src);
    if (slot[1].v && slot[1].ctl[10] && !slot[1].ctl[9] && slot[1].rd != 5'd0 && slot[1].rd == src) return 1;
    if (slot[2].v && slot[2].ctl[10] && slot[2].rd != 5'd0 && slot[2].rd == src) return 2;
    return 0;
  endfunction

  task automatic model_step();
    bit lu;
    bit redir;
    if (reset !== 1'b1) begin
      model_reset();
      return;
    end
    lu    = model_load_use();
    redir = bus.ex_redirect;
    if (lu && !redir && m_lu_cnt < CNT_MAX) m_lu_cnt++;
    if (redir && m_rd_cnt < CNT_MAX) m_rd_cnt++;
    slot[2] = slot[1];
    slot[1] = slot[0];
    if (redir || lu) slot[0] = '{1'b0, 11'd0, 5'd0, 5'd0, 5'd0};
    else slot[0] = '{bus.id_valid, bus.id_valid ? bus.id_ctl : 11'd0, bus.id_rs1, bus.id_rs2, bus.id_rd};
  endtask

  task automatic compare_model();
    check("stall", bus.stall, model_load_use() && !bus.ex_redirect);
    check("flush_id", bus.flush_id, bus.ex_redirect);
    check("ex_valid", bus.ex_valid, slot[0].v);
    check("mem_valid", bus.mem_valid, slot[1].v);
    check("wb_valid", bus.wb_valid, slot[2].v);
    check("ex_ctl", bus.ex_ctl, slot[0].ctl);
    check("mem_ctl", bus.mem_ctl, slot[1].ctl);
    check("wb_ctl", bus.wb_ctl, slot[2].ctl);
    if (slot[0].v) begin
      check("ex_rs1", bus.ex_rs1, slot[0].rs1);
      check("ex_rs2", bus.ex_rs2, slot[0].rs2);
      check("ex_rd", bus.ex_rd, slot[0].rd);
      check("fwd_a", bus.fwd_a_select, model_fwd(slot[0].rs1));
      check("fwd_b", bus.fwd_b_select, model_fwd(slot[0].rs2));
    end
    if (slot[1].v) check("mem_rd", bus.mem_rd, slot[1].rd);
    if (slot[2].v) check("wb_rd", bus.wb_rd, slot[2].rd);
    check("load_use_count", bus.load_use_count, m_lu_cnt);
    check("redirect_count", bus.redirect_count, m_rd_cnt);
  endtask

  task automatic drive(input bit v, input bit [10:0] ctl, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit [4:0] rd, input bit u1, input bit u2, input bit redir);
    bus.id_valid    = v;
    bus.id_ctl      = ctl;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_uses_rs1 = u1;
    bus.id_uses_rs2 = u2;
    bus.ex_redirect = redir;
  endtask

  task automatic idle();
    drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clock);
    compare_model();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    model_step();
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    idle();
    repeat (2) @(posedge clock);
    #1;
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_wb_ctl", bus.wb_ctl, 11'd0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_fwd_a", bus.fwd_a_select, 2'd0);
    check("rst_lu_cnt", bus.load_use_count, 6'd0);
    release_reset();

    // lw x5 ; add x6,x5,x1 -> one stall, then WB forwarding
    drive(1'b1, CTL_LW, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, CTL_ADD, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0); #1;
    check("t1_stall", bus.stall, 1'b1);
    tick();
    check("t1_bubble", bus.ex_valid, 1'b0);
    check("t1_lu_cnt", bus.load_use_count, 6'd1);
    check("t1_stall_gone", bus.stall, 1'b0);
    tick();
    idle(); #1;
    check("t1_ex_valid", bus.ex_valid, 1'b1);
    check("t1_fwd_a", bus.fwd_a_select, 2'd2);

    // add x3,x1,x2 ; sub x4,x3,x3 -> MEM forwarding on both operands
    drive(1'b1, CTL_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, CTL_SUB, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0); #1;
    check("t2_no_stall", bus.stall, 1'b0);
    tick();
    idle(); #1;
    check("t2_fwd_a", bus.fwd_a_select, 2'd1);
    check("t2_fwd_b", bus.fwd_b_select, 2'd1);

    // two writers of x7 in MEM and WB -> MEM wins
    drive(1'b1, CTL_ADD, 5'd1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, CTL_ADD, 5'd2, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, CTL_SUB, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0); tick();
    idle(); #1;
    check("t3_fwd_a", bus.fwd_a_select, 2'd1);
    check("t3_fwd_b", bus.fwd_b_select, 2'd0);

    // load to x0 never stalls or forwards
    drive(1'b1, CTL_LW, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, CTL_ADD, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0); #1;
    check("t4_no_stall", bus.stall, 1'b0);
    tick();
    idle(); #1;
    check("t4_fwd_a", bus.fwd_a_select, 2'd0);

    // load-use coinciding with redirect -> redirect wins
    drive(1'b1, CTL_LW, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, CTL_ADD, 5'd9, 5'd1, 5'd10, 1'b1, 1'b0, 1'b1); #1;
    check("t5_stall", bus.stall, 1'b0);
    check("t5_flush", bus.flush_id, 1'b1);
    tick();
    idle(); #1;
    check("t5_bubble", bus.ex_valid, 1'b0);
    check("t5_rd_cnt", bus.redirect_count, 6'd1);
    check("t5_lu_cnt", bus.load_use_count, 6'd1);

    // reset asserted while stalling
    drive(1'b1, CTL_LW, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, CTL_ADD, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0); #1;
    check("t6_stall", bus.stall, 1'b1);
    #1 reset = 1'b0;
    #1;
    model_reset();
    check("t6_stall_drop", bus.stall, 1'b0);
    check("t6_ex_valid", bus.ex_valid, 1'b0);
    check("t6_ex_ctl", bus.ex_ctl, 11'd0);
    check("t6_rd_cnt", bus.redirect_count, 6'd0);
    idle();
    release_reset();

    // redirect counter saturation
    drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (62) tick();
    check("t7_cnt_62", bus.redirect_count, 6'd62);
    tick();
    check("t7_cnt_63", bus.redirect_count, 6'd63);
    tick();
    check("t7_cnt_sat", bus.redirect_count, 6'd63);

    // random traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("rnd_reset_stall", bus.stall, 1'b0);
        idle();
        release_reset();
      end
      drive($urandom_range(0, 3) != 0, 11'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_regs.md
Name: pipeline_hazard_regs

Overview:
Control-side pipeline register chain (ID→EX→MEM→WB) directly downstream of the decode control path.
- Captures the packed decoded control word with register addresses each cycle.
- Detects load-use hazards and requests a front-end stall.
- Squashes the wrong-path ID instruction on an EX redirect.
- Generates EX operand forwarding selects.
- Keeps saturating hazard event counters.

Parameters:
CTL_W, 11, packed control width {regfile_write_enable, data_mem_read_enable, data_mem_write_enable, reg_writeback_select[2:0], alu_function[4:0]}, MSB first
REG_ADDR_W, 5, register address width
COUNT_W, 32, hazard counter width

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID slot holds a real instruction
id_ctl  in  CTL_W  decoded control word
id_rs1 / id_rs2 / id_rd  in  REG_ADDR_W each  ID register addresses
id_uses_rs1 / id_uses_rs2  in  1 each  ID instruction reads rs1/rs2
ex_redirect  in  1  EX resolved a taken branch/jump this cycle
stall  out  1  hold PC and IF/ID this cycle (comb.)
flush_id  out  1  ID instruction is wrong-path (= ex_redirect)
ex_valid / mem_valid / wb_valid  out  1 each  stage occupancy
ex_ctl / mem_ctl / wb_ctl  out  CTL_W each  stage control words
ex_rs1 / ex_rs2  out  REG_ADDR_W each  EX source addresses
ex_rd / mem_rd / wb_rd  out  REG_ADDR_W each  stage destination addresses
fwd_a_select / fwd_b_select  out  2 each  EX operand source: 0 regfile, 1 MEM result, 2 WB result
load_use_count / redirect_count  out  COUNT_W each  event counters

Behaviour:
- Reset (async assert, sync release): all valid=0, ctl=0, addresses=0, counters=0. Consequently stall=0 and fwd selects=0.
- Bubble: valid=0 and ctl=0, so no write or memory enables escape.
- MEM←EX and WB←MEM advance every cycle unconditionally. Latency ID→WB is 3 cycles absent stalls.
- load_use (comb.) = id_valid & ex_valid & ex_ctl.data_mem_read_enable & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- stall = load_use & ~ex_redirect.
- EX next-state:
  - if ex_redirect or stall → bubble;
  - else EX ← {id_valid, id_valid ? id_ctl : 0, id_rs1, id_rs2, id_rd}.
- Redirect beats a simultaneous load-use: stall=0, the ID instruction is dropped, and load_use_count does not increment.
- id_valid=0 inserts a bubble; the address fields are still copied but are ignored because valid=0.
- Forwarding (comb.) for fwd_a; fwd_b is identical with ex_rs2:
  - 1 if mem_valid & mem_ctl.regfile_write_enable & ~mem_ctl.data_mem_read_enable & mem_rd≠0 & mem_rd==ex_rs1;
  - else 2 if wb_valid & wb_ctl.regfile_write_enable & wb_rd≠0 & wb_rd==ex_rs1;
  - else 0.
  - MEM has priority over WB. Register x0 is never forwarded.
- A load in MEM is never forwarded. The stall guarantees its consumer reaches EX only when the load is in WB.
- Counters increment by 1 per cycle in which stall=1 or ex_redirect=1 respectively. They saturate at all-ones with no wrap.
- Reset asserted mid-stall: state clears immediately and stall drops in the same cycle.
- Inputs are sampled only at clock edges; no handshake beyond stall/flush.

Test Plan:
- Reset, then lw x5 in ID then add x6,x5,x1 with id_uses_rs1=1 → one cycle stall=1, EX bubble, load_use_count=1. The add enters EX the next cycle with fwd_a_select=2.
- add x3,x1,x2 followed by sub x4,x3,x3 → no stall; sub in EX gets fwd_a_select=fwd_b_select=1.
- Back-to-back writers x7 in MEM and WB, consumer reads x7 → select=1 (MEM priority).
- Writer with rd=x0 in MEM, consumer reads x0 → select=0, no stall even if the writer is a load.
- Load-use condition and ex_redirect=1 in the same cycle → stall=0, flush_id=1, EX bubble next cycle, redirect_count+1, load_use_count unchanged.
- Force redirect_count to all-ones-1, two redirects → saturates at all-ones. Assert reset mid-run → all outputs 0 asynchronously.
